cpu_run_ctrl: RTL and testbench
===============================

CPU_RUN_CTRL -- requirements
Module: cpu_run_ctrl

Interface
REQ-001 Parameter ADDR_W, default 32, width of the program-counter load value.
REQ-002 Parameter NUM_PROGS, default 4, number of selectable boot entries.
REQ-003 Parameter SEL_W, default 2, width of prog_sel; SHALL satisfy 2**SEL_W >= NUM_PROGS.
REQ-004 Parameter BOOT_ADDRS, default {32'h60, 32'h40, 32'h20, 32'h0}, NUM_PROGS*ADDR_W packed boot addresses; entry i occupies bits [i*ADDR_W +: ADDR_W].
REQ-005 Parameter RUN_DELAY, default 3, cycles between the pc_ld pulse and run_en assertion; minimum 1.
REQ-006 Parameter CNT_W, default 16, cycle-counter width.
REQ-007 Parameter MAX_CYCLES, default 1250, run-cycle timeout; SHALL be in the range 1 to 2**CNT_W-1.
REQ-008 Parameter AUTO_START, default 0; 1 = launch entry 0 automatically on the first cycle after reset release.
REQ-009 clk  in  1  single clock; all state changes on the rising edge.
REQ-010 reset_n  in  1  reset, asynchronous assert, active-low.
REQ-011 start  in  1  launch request, sampled in IDLE/DONE only.
REQ-012 prog_sel  in  SEL_W  boot entry index, sampled with start.
REQ-013 halt  in  1  CPU halt indication, sampled in RUN only.
REQ-014 abort  in  1  synchronous cancel, valid in any state.
REQ-015 pc_ld  out  1  one-cycle PC load strobe.
REQ-016 pc_data  out  ADDR_W  PC load value, valid while pc_ld=1.
REQ-017 run_en  out  1  CPU run enable.
REQ-018 done  out  1  run finished (halted or timed out).
REQ-019 timeout  out  1  last run ended by MAX_CYCLES.
REQ-020 bad_sel  out  1  last launch used prog_sel >= NUM_PROGS.
REQ-021 cycle_count  out  CNT_W  RUN cycles elapsed in current/last run.

Function
REQ-022 FSM states SHALL be IDLE, LOAD, SETTLE, RUN and DONE, all registered.
REQ-023 IDLE, start=1 -> LOAD next cycle; prog_sel latched; cycle_count, timeout and done cleared.
REQ-024 AUTO_START=1: first clock after reset release acts as start with prog_sel=0.
REQ-025 LOAD lasts exactly 1 cycle: pc_ld=1 and pc_data=BOOT_ADDRS[latched sel]; next state is SETTLE.
REQ-026 If latched sel >= NUM_PROGS, entry 0 is used and bad_sel is set; otherwise bad_sel is cleared.
REQ-027 pc_data SHALL be 0 whenever pc_ld=0.
REQ-028 SETTLE lasts exactly RUN_DELAY cycles; next state is RUN.
REQ-029 run_en SHALL be 1 exactly while in RUN; first run_en=1 cycle is RUN_DELAY+1 cycles after the pc_ld cycle.
REQ-030 RUN: cycle_count increments by 1 each cycle, counting the first RUN cycle as 1.
REQ-031 RUN, halt=1 -> DONE, timeout=0, cycle_count frozen at the current value.
REQ-032 RUN, cycle_count reaching MAX_CYCLES with halt=0 -> DONE, timeout=1, cycle_count=MAX_CYCLES.
REQ-033 Halt and timeout in the same cycle: halt wins, timeout=0.
REQ-034 cycle_count SHALL never wrap.
REQ-035 DONE: done=1, run_en=0, cycle_count/timeout/bad_sel held; start=1 relaunches as in REQ-023.
REQ-036 start in LOAD, SETTLE or RUN SHALL be ignored (no queueing).
REQ-037 abort=1 in any state -> IDLE next cycle; run_en, pc_ld and done cleared; cycle_count held.
REQ-038 abort=1 and start=1 together: abort wins.

Reset
REQ-039 reset_n=0 SHALL immediately force IDLE with pc_ld=0, pc_data=0, run_en=0, done=0, timeout=0, bad_sel=0, cycle_count=0, including mid-run.
REQ-040 Reset release SHALL take effect on the next rising clk; no output changes between edges.

Verification
REQ-041 Defaults; start with prog_sel=1; halt on the 10th RUN cycle -> one pc_ld pulse with pc_data=0x20, run_en 4 cycles later, done=1, cycle_count=10, timeout=0.
REQ-042 MAX_CYCLES=5, halt never asserted -> done=1, timeout=1, cycle_count=5, run_en high exactly 5 cycles.
REQ-043 MAX_CYCLES=5, halt on the 5th RUN cycle -> timeout=0, cycle_count=5.
REQ-044 prog_sel=5 with NUM_PROGS=4 -> pc_data=0x0, bad_sel=1; next launch with prog_sel=2 -> pc_data=0x40, bad_sel=0.
REQ-045 reset_n pulled low mid-RUN between clock edges -> run_en=0 and cycle_count=0 immediately; AUTO_START=1 -> relaunch with pc_data=0x0 after release.
REQ-046 start pulses during SETTLE and RUN ignored; abort during RUN -> IDLE, run_en=0 next cycle, done=0.

Source files
------------

// File: rtl/cpu_run_ctrl_if.sv
// cpu_run_ctrl_if: launch/halt control and PC-load/run-status bundle between run controller and CPU side.
interface cpu_run_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int SEL_W  = 2,
  parameter int CNT_W  = 16
);
  logic              start;
  logic [SEL_W-1:0]  prog_sel;
  logic              halt;
  logic              abort;
  logic              pc_ld;
  logic [ADDR_W-1:0] pc_data;
  logic              run_en;
  logic              done;
  logic              timeout;
  logic              bad_sel;
  logic [CNT_W-1:0]  cycle_count;
  modport master (
    input  start, prog_sel, halt, abort,
    output pc_ld, pc_data, run_en, done, timeout, bad_sel, cycle_count
  );
  modport slave (
    output start, prog_sel, halt, abort,
    input  pc_ld, pc_data, run_en, done, timeout, bad_sel, cycle_count
  );
endinterface

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: boots a CPU from a selectable entry, holds it in reset-settle, then runs it until halt or cycle timeout.
module cpu_run_ctrl #(
  parameter int ADDR_W     = 32,
  parameter int NUM_PROGS  = 4,
  parameter int SEL_W      = 2,
  parameter logic [NUM_PROGS*ADDR_W-1:0] BOOT_ADDRS = {32'h60, 32'h40, 32'h20, 32'h0},
  parameter int RUN_DELAY  = 3,
  parameter int CNT_W      = 16,
  parameter int MAX_CYCLES = 1250,
  parameter int AUTO_START = 0
) (
  input logic clk,
  input logic reset_n,
  cpu_run_ctrl_if.master bus
);
  typedef enum logic [2:0] {IDLE, LOAD, SETTLE, RUN, DONE} state_t;
  localparam int DW = RUN_DELAY > 1 ? $clog2(RUN_DELAY) : 1;
  state_t            state_q;
  logic [DW-1:0]     dly_q;
  logic              auto_q;
  logic              pc_ld_q, run_en_q, done_q, timeout_q, bad_sel_q;
  logic [ADDR_W-1:0] pc_data_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              go_d, bad_d;
  logic [SEL_W-1:0]  sel_d;
  logic [ADDR_W-1:0] addr_d;
  // auto_q stands in for a start with entry 0 on the first clock after reset
  always_comb begin
    go_d   = (auto_q || bus.start) && (state_q == IDLE || state_q == DONE);
    sel_d  = auto_q ? '0 : bus.prog_sel;
    bad_d  = int'(sel_d) >= NUM_PROGS;
    addr_d = BOOT_ADDRS[ADDR_W-1:0];
    for (int i = 0; i < NUM_PROGS; i++)
      if (int'(sel_d) == i) addr_d = BOOT_ADDRS[i*ADDR_W +: ADDR_W];
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      dly_q     <= '0;
      auto_q    <= AUTO_START != 0;
      pc_ld_q   <= 1'b0;
      pc_data_q <= '0;
      run_en_q  <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      bad_sel_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      auto_q <= 1'b0;
      if (bus.abort) begin
        state_q   <= IDLE;
        pc_ld_q   <= 1'b0;
        pc_data_q <= '0;
        run_en_q  <= 1'b0;
        done_q    <= 1'b0;
      end else if (go_d) begin
        state_q   <= LOAD;
        pc_ld_q   <= 1'b1;
        pc_data_q <= addr_d;
        bad_sel_q <= bad_d;
        cnt_q     <= '0;
        timeout_q <= 1'b0;
        done_q    <= 1'b0;
      end else begin
        case (state_q)
          LOAD: begin
            state_q   <= SETTLE;
            pc_ld_q   <= 1'b0;
            pc_data_q <= '0;
            dly_q     <= DW'(RUN_DELAY - 1);
          end
          SETTLE: begin
            if (dly_q == '0) begin
              state_q  <= RUN;
              run_en_q <= 1'b1;
              cnt_q    <= CNT_W'(1);
            end else dly_q <= dly_q - 1'b1;
          end
          RUN: begin
            // halt takes priority over a simultaneous timeout
            if (bus.halt || cnt_q == CNT_W'(MAX_CYCLES)) begin
              state_q   <= DONE;
              run_en_q  <= 1'b0;
              done_q    <= 1'b1;
              timeout_q <= !bus.halt;
            end else cnt_q <= cnt_q + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end
  assign bus.pc_ld       = pc_ld_q;
  assign bus.pc_data     = pc_data_q;
  assign bus.run_en      = run_en_q;
  assign bus.done        = done_q;
  assign bus.timeout     = timeout_q;
  assign bus.bad_sel     = bad_sel_q;
  assign bus.cycle_count = cnt_q;
endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb_cpu_run_ctrl: directed checks of launch, settle, run, halt, timeout, abort and reset on three configurations.
module tb_cpu_run_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst_n_c = 1'b0;
  int total = 0;
  int bad = 0;
  int npl_a = 0;
  int nrun_b = 0;
  int n;
  int c;
  always #5 clk = ~clk;

  cpu_run_ctrl_if #(.ADDR_W(32), .SEL_W(2), .CNT_W(16)) ia ();
  cpu_run_ctrl_if #(.ADDR_W(32), .SEL_W(3), .CNT_W(16)) ib ();
  cpu_run_ctrl_if #(.ADDR_W(32), .SEL_W(2), .CNT_W(16)) ic ();

  cpu_run_ctrl u_a (.clk(clk), .reset_n(rst_n), .bus(ia.master));
  cpu_run_ctrl #(.SEL_W(3), .MAX_CYCLES(5)) u_b (.clk(clk), .reset_n(rst_n), .bus(ib.master));
  cpu_run_ctrl #(.AUTO_START(1)) u_c (.clk(clk), .reset_n(rst_n_c), .bus(ic.master));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    npl_a += int'(ia.pc_ld);
    nrun_b += int'(ib.run_en);
  endtask

  initial begin
    {ia.start, ia.prog_sel, ia.halt, ia.abort} = '0;
    {ib.start, ib.prog_sel, ib.halt, ib.abort} = '0;
    {ic.start, ic.prog_sel, ic.halt, ic.abort} = '0;
    #2;
    check("rst_pc_ld", ia.pc_ld, 0);
    check("rst_pc_data", ia.pc_data, 0);
    check("rst_run_en", ia.run_en, 0);
    check("rst_done", ia.done, 0);
    check("rst_cnt", ia.cycle_count, 0);
    step();
    step();
    rst_n = 1'b1;
    rst_n_c = 1'b1;
    npl_a = 0;
    step();
    check("c_auto_pc_ld", ic.pc_ld, 1);
    check("c_auto_pc_data", ic.pc_data, 0);
    check("a_idle_pc_ld", ia.pc_ld, 0);

    // A: entry 1, start pulses ignored in SETTLE/RUN, halt on RUN cycle 10
    ia.start = 1'b1;
    ia.prog_sel = 2'd1;
    step();
    ia.start = 1'b0;
    check("a_load_pc_ld", ia.pc_ld, 1);
    check("a_load_pc_data", ia.pc_data, 32'h20);
    check("a_load_bad_sel", ia.bad_sel, 0);
    n = 0;
    do begin
      if (n == 1) ia.start = 1'b1;
      step();
      ia.start = 1'b0;
      n++;
      if (n == 1) check("a_settle_pc_data", ia.pc_data, 0);
    end while (!ia.run_en && n < 10);
    check("a_run_delay", n, 4);
    check("a_run_cnt1", ia.cycle_count, 1);
    ia.start = 1'b1;
    step();
    ia.start = 1'b0;
    check("a_run_start_ign_ld", ia.pc_ld, 0);
    check("a_run_start_ign_en", ia.run_en, 1);
    check("a_run_cnt2", ia.cycle_count, 2);
    n = 0;
    while (ia.cycle_count < 10 && n < 20) begin
      step();
      n++;
    end
    check("a_run_cnt10", ia.cycle_count, 10);
    ia.halt = 1'b1;
    step();
    ia.halt = 1'b0;
    check("a_halt_done", ia.done, 1);
    check("a_halt_run_en", ia.run_en, 0);
    check("a_halt_cnt", ia.cycle_count, 10);
    check("a_halt_timeout", ia.timeout, 0);
    check("a_pc_ld_pulses", npl_a, 1);
    step();
    check("a_done_hold_cnt", ia.cycle_count, 10);
    check("a_done_hold", ia.done, 1);

    // A: relaunch entry 2, abort mid-run
    ia.start = 1'b1;
    ia.prog_sel = 2'd2;
    step();
    ia.start = 1'b0;
    check("a_relaunch_pc_data", ia.pc_data, 32'h40);
    check("a_relaunch_done", ia.done, 0);
    check("a_relaunch_cnt", ia.cycle_count, 0);
    n = 0;
    while (!ia.run_en && n < 10) begin
      step();
      n++;
    end
    step();
    step();
    check("a_pre_abort_cnt", ia.cycle_count, 3);
    c = int'(ia.cycle_count);
    ia.abort = 1'b1;
    step();
    ia.abort = 1'b0;
    check("a_abort_run_en", ia.run_en, 0);
    check("a_abort_done", ia.done, 0);
    check("a_abort_cnt", ia.cycle_count, 64'(c));
    ia.abort = 1'b1;
    ia.start = 1'b1;
    step();
    {ia.abort, ia.start} = '0;
    check("a_abort_wins", ia.pc_ld, 0);
    step();
    check("a_idle_stays", ia.run_en, 0);

    // B: out-of-range entry, timeout at 5
    ib.start = 1'b1;
    ib.prog_sel = 3'd5;
    step();
    ib.start = 1'b0;
    check("b_bad_pc_ld", ib.pc_ld, 1);
    check("b_bad_pc_data", ib.pc_data, 0);
    check("b_bad_sel", ib.bad_sel, 1);
    nrun_b = 0;
    n = 0;
    while (!ib.done && n < 30) begin
      step();
      n++;
    end
    check("b_to_done", ib.done, 1);
    check("b_to_timeout", ib.timeout, 1);
    check("b_to_cnt", ib.cycle_count, 5);
    check("b_to_run_cycles", nrun_b, 5);
    check("b_to_bad_hold", ib.bad_sel, 1);
    ib.start = 1'b1;
    ib.prog_sel = 3'd2;
    step();
    ib.start = 1'b0;
    check("b_good_pc_data", ib.pc_data, 32'h40);
    check("b_good_bad_sel", ib.bad_sel, 0);
    check("b_good_timeout_clr", ib.timeout, 0);
    n = 0;
    while (ib.cycle_count < 5 && n < 30) begin
      step();
      n++;
    end
    check("b_pre_halt_en", ib.run_en, 1);
    ib.halt = 1'b1;
    step();
    ib.halt = 1'b0;
    check("b_halt_vs_to_done", ib.done, 1);
    check("b_halt_vs_to_timeout", ib.timeout, 0);
    check("b_halt_vs_to_cnt", ib.cycle_count, 5);

    // C: asynchronous reset mid-run, then auto relaunch
    check("c_running", ic.run_en, 1);
    #3;
    rst_n_c = 1'b0;
    #1;
    check("c_arst_run_en", ic.run_en, 0);
    check("c_arst_cnt", ic.cycle_count, 0);
    check("c_arst_pc_ld", ic.pc_ld, 0);
    step();
    step();
    rst_n_c = 1'b1;
    #3;
    check("c_rel_no_change", ic.pc_ld, 0);
    step();
    check("c_relaunch_pc_ld", ic.pc_ld, 1);
    check("c_relaunch_pc_data", ic.pc_data, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
